// File: rtl/sawwave_generator.sv
// -----------------------------------------------------------------------------
// sawwave_generator
//   Digital sawtooth for a downstream PWM duty input. A 6-bit phase ramps
//   0..63 in unit steps and wraps to 0. Each step lasts
//   T = (Scale+1)*BASE_DIV sysclk cycles, gated by a run-enable switch.
//
// Ports
//   sysclk       in   1  system clock, all logic on the rising edge
//   Reset_n      in   1  asynchronous active-low reset
//   Scale        in   6  rate select, sampled every cycle
//   Enable_SW_1  in   1  run enable (already synchronised upstream)
//   Duty_Output  out  6  registered sawtooth sample
// -----------------------------------------------------------------------------
module sawwave_generator #(
   parameter int BASE_DIV = 64,   // cycles per step at Scale=0, >= 1
   parameter int PS_W     = 13    // must hold 64*BASE_DIV-1
) (
   input  logic       sysclk,
   input  logic       Reset_n,
   input  logic [5:0] Scale,
   input  logic       Enable_SW_1,
   output logic [5:0] Duty_Output
);

   logic [PS_W-1:0] ps_q, ps_d;
   logic [5:0]      duty_q, duty_d;
   logic [PS_W-1:0] tc;

   // Terminal count from the live Scale. Computed at PS_W bits so a Scale
   // change mid-step takes effect on the very next comparison.
   always_comb begin
      tc = ({{(PS_W-6){1'b0}}, Scale} + PS_W'(1)) * PS_W'(BASE_DIV) - PS_W'(1);
   end

   // Disable has priority over a terminal count landing on the same edge.
   // Using >= rather than == lets a shrinking Scale step immediately when the
   // prescaler is already past the new terminal count.
   always_comb begin
      ps_d   = ps_q;
      duty_d = duty_q;
      if (!Enable_SW_1) begin
         ps_d   = '0;
         duty_d = '0;
      end else if (ps_q >= tc) begin
         ps_d   = '0;
         duty_d = duty_q + 6'd1;   // natural 6-bit wrap 63 -> 0
      end else begin
         ps_d   = ps_q + PS_W'(1);
      end
   end

   always_ff @(posedge sysclk or negedge Reset_n) begin
      if (!Reset_n) begin
         ps_q   <= '0;
         duty_q <= '0;
      end else begin
         ps_q   <= ps_d;
         duty_q <= duty_d;
      end
   end

   assign Duty_Output = duty_q;

endmodule

// File: tb/tb_sawwave_generator.sv
// -----------------------------------------------------------------------------
// tb_sawwave_generator
//   Directed bench for sawwave_generator at default parameters
//   (BASE_DIV=64, so T = (Scale+1)*64). Expected values are hand-derived
//   edge counts from a known prescaler position.
// -----------------------------------------------------------------------------
module tb_sawwave_generator;

   logic       sysclk;
   logic       Reset_n;
   logic [5:0] Scale;
   logic       Enable_SW_1;
   logic [5:0] Duty_Output;

   int n_chk  = 0;
   int n_pass = 0;

   sawwave_generator dut (
      .sysclk      (sysclk),
      .Reset_n     (Reset_n),
      .Scale       (Scale),
      .Enable_SW_1 (Enable_SW_1),
      .Duty_Output (Duty_Output)
   );

   initial begin
      sysclk = 1'b0;
      forever #5 sysclk = ~sysclk;
   end

   // Safety net: the directed sequence is ~18k cycles.
   initial begin
      #2_000_000;
      $display("FAIL timeout: run did not finish, got %0d/%0d checks", n_pass, n_chk);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // Advance n rising edges, then settle 1 time unit past the last edge.
   task automatic clk(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   initial begin
      Reset_n     = 1'b0;
      Scale       = 6'd12;
      Enable_SW_1 = 1'b1;

      // Reset state, including across edges while held.
      #2;
      chk("rst_init", Duty_Output, 6'd0);
      clk(3);
      chk("rst_held", Duty_Output, 6'd0);

      // First step at edge 832 after release (Scale=12, T=832).
      @(negedge sysclk);
      Reset_n = 1'b1;
      clk(831);
      chk("first_pre", Duty_Output, 6'd0);
      clk(1);
      chk("first_step", Duty_Output, 6'd1);
      clk(831);
      chk("s12_hold", Duty_Output, 6'd1);
      clk(1);
      chk("s12_step", Duty_Output, 6'd2);

      // Scale shrink with ps=500 past new TC=191: step on next edge.
      clk(500);
      Scale = 6'd2;
      clk(1);
      chk("shrink_now", Duty_Output, 6'd3);
      clk(191);
      chk("s2_hold", Duty_Output, 6'd3);
      clk(1);
      chk("s2_step", Duty_Output, 6'd4);
      clk(191);
      chk("s2_hold2", Duty_Output, 6'd4);
      clk(1);
      chk("s2_step2", Duty_Output, 6'd5);

      // Scale=0: a step every 64 cycles, every value held exactly 64, then wrap.
      Scale = 6'd0;
      for (int v = 5; v < 63; v++) begin
         clk(63);
         chk("ramp_hold", Duty_Output, 6'(v));
         clk(1);
         chk("ramp_step", Duty_Output, 6'(v + 1));
      end
      clk(63);
      chk("top_hold", Duty_Output, 6'd63);
      clk(1);
      chk("wrap", Duty_Output, 6'd0);

      // Collision: disable lands on the terminal-count edge at 63.
      clk(63 * 64);
      chk("to_63", Duty_Output, 6'd63);
      clk(63);
      Enable_SW_1 = 1'b0;
      clk(1);
      chk("collision", Duty_Output, 6'd0);
      clk(100);
      chk("dis_hold", Duty_Output, 6'd0);
      // Fresh prescale on re-enable proves ps was cleared.
      Enable_SW_1 = 1'b1;
      clk(63);
      chk("reen_pre", Duty_Output, 6'd0);
      clk(1);
      chk("reen_step", Duty_Output, 6'd1);

      // Drop enable mid-step at 37.
      clk(36 * 64);
      chk("to_37", Duty_Output, 6'd37);
      clk(10);
      Enable_SW_1 = 1'b0;
      clk(1);
      chk("drop37", Duty_Output, 6'd0);
      clk(99);
      chk("drop37_hold", Duty_Output, 6'd0);

      // Scale=63: a step every 4096 cycles.
      Scale       = 6'd63;
      Enable_SW_1 = 1'b1;
      clk(4095);
      chk("s63_pre", Duty_Output, 6'd0);
      clk(1);
      chk("s63_step", Duty_Output, 6'd1);

      // Larger Scale extends the current step: ps=40, then TC=127.
      Scale = 6'd0;
      clk(40);
      Scale = 6'd1;
      clk(87);
      chk("extend_hold", Duty_Output, 6'd1);
      clk(1);
      chk("extend_step", Duty_Output, 6'd2);

      // Asynchronous reset mid-cycle clears immediately and stays clear.
      clk(20);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("async_rst", Duty_Output, 6'd0);
      clk(2);
      chk("async_held", Duty_Output, 6'd0);
      @(negedge sysclk);
      Reset_n = 1'b1;
      clk(127);
      chk("post_rst_pre", Duty_Output, 6'd0);
      clk(1);
      chk("post_rst_step", Duty_Output, 6'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
